cl_encode: RTL and testbench
============================

CL_ENCODE -- requirements
Module: cl_encode

Interface
REQ-001 Parameter CNT_W, default 9, sets the run-length counter width; the maximum run is 2^CNT_W-1.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  in_len/in_last valid.
REQ-005 in_ready  output  1  block accepts input this cycle; transfer occurs when in_valid&&in_ready.
REQ-006 in_len  input  4  code length 0..15.
REQ-007 in_last  input  1  marks final code length of the sequence.
REQ-008 out_valid  output  1  output symbol valid.
REQ-009 out_ready  input  1  downstream accepts; transfer occurs when out_valid&&out_ready.
REQ-010 out_sym  output  5  code-length alphabet symbol 0..18.
REQ-011 out_extra  output  7  extra-bit value, LSB-aligned; 0 for symbols 0..15.
REQ-012 out_extra_bits  output  3  number of extra bits: 0 for sym 0..15, 2 for 16, 3 for 17, 7 for 18.
REQ-013 out_last  output  1  asserted with the final symbol of the sequence.

Function
REQ-014 The block shall run-length encode a code-length sequence into the DEFLATE code-length alphabet (RFC 1951 3.2.7).
REQ-015 States: S_ACC (collect run), S_EMIT (emit symbols of the held run), S_TAIL (emit the final single-value run after a value change on last).
REQ-016 In S_ACC, in_ready=1. In S_EMIT and S_TAIL, in_ready=0.
REQ-017 In S_ACC, an accepted in_len equal to cur_val, with run_cnt<2^CNT_W-1 and in_last=0, shall increment run_cnt with no output.
REQ-018 In S_ACC, an accepted in_len that differs from cur_val, or arrives while run_cnt is saturated, shall end the run: copy {cur_val, run_cnt} to {emit_val, emit_cnt}, set cur_val=in_len, run_cnt=1, and enter S_EMIT.
REQ-019 The first accepted input after reset, or after completion of a sequence, shall only load cur_val and set run_cnt=1.
REQ-020 An accepted in_last with in_len equal to cur_val (run not saturated) shall add the input to the run and enter S_EMIT with final=1.
REQ-021 An accepted in_last that ends a run shall enter S_EMIT with pend_tail=1. After that run finishes, the block shall emit cur_val (count 1) in S_TAIL with final=1.
REQ-022 Zero runs (emit_val=0), emitted greedily, one symbol per output handshake:
- while emit_cnt>=11: sym 18, extra=min(emit_cnt,138)-11, subtract min(emit_cnt,138);
- else if emit_cnt>=3: sym 17, extra=emit_cnt-3, subtract emit_cnt;
- else: literal 0, subtract 1.
REQ-023 Nonzero runs:
- first emit literal emit_val and subtract 1;
- then while remaining>=3: sym 16, extra=min(rem,6)-3, subtract min(rem,6);
- remaining 1..2: literal emit_val each, subtract 1.
REQ-024 The first output symbol shall be valid the cycle after the run-terminating input is accepted. After each handshake, the next symbol shall be valid the following cycle (1 symbol/cycle when out_ready stays 1).
REQ-025 When out_valid=1 and out_ready=0, out_sym, out_extra, out_extra_bits and out_last shall hold stable.
REQ-026 When emit_cnt reaches 0:
- pend_tail → S_TAIL;
- final → S_ACC with run_cnt=0 (fresh sequence);
- otherwise → S_ACC.
REQ-027 out_last shall be 1 only on the last symbol when final=1.
REQ-028 A sequence of one input with in_last=1 shall emit exactly one literal symbol with out_last=1.

Reset
REQ-029 reset=1 at a clock edge shall force: state S_ACC; run_cnt=0; cur_val=0; emit_cnt=0; final=0; pend_tail=0; out_valid=0; out_sym=0; out_extra=0; out_extra_bits=0; out_last=0.
REQ-030 Reset asserted mid-run or mid-emit shall abandon all pending symbols; in_ready=1 the cycle after reset deasserts.

Verification
REQ-031 Input 5×8, last on the 8th, out_ready=1 → (5,-,0), (16,3,2), (5,-,0, last).
REQ-032 Input 0×20 then 3 (last) → (18,9,7), (3,0,0, last).
REQ-033 Input 0×139, last → (18,127,7), (0,0,0, last). Input 0×7, last → (17,4,3, last).
REQ-034 Input 0,0,7 (last) → 0, 0, 7(last). in_ready=0 during emission.
REQ-035 Backpressure: during REQ-031, hold out_ready=0 for 5 cycles on (16,3,2) → outputs stable, in_ready=0, and the same symbol sequence results.
REQ-036 Assert reset during emission of REQ-032 → out_valid=0 the next cycle, no further symbols, and a new sequence 4 (last) → (4,0,0, last).

Source files
------------

// File: rtl/cl_encode_if.sv
// Stream bundle for the code-length run-length encoder: code lengths in,
// code-length alphabet symbols with extra bits out.
interface cl_encode_if;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_len;
   logic       in_last;
   logic       out_valid;
   logic       out_ready;
   logic [4:0] out_sym;
   logic [6:0] out_extra;
   logic [2:0] out_extra_bits;
   logic       out_last;

   modport slave (
      input  in_valid, in_len, in_last, out_ready,
      output in_ready, out_valid, out_sym, out_extra, out_extra_bits, out_last
   );

   modport master (
      output in_valid, in_len, in_last, out_ready,
      input  in_ready, out_valid, out_sym, out_extra, out_extra_bits, out_last
   );
endinterface

// File: rtl/cl_encode.sv
// DEFLATE code-length run-length encoder: collects runs of equal code lengths
// and emits them greedily as literals and repeat symbols 16/17/18.
module cl_encode #(
   parameter int CNT_W = 9
) (
   input  logic         clk,
   input  logic         reset,
   cl_encode_if.slave   bus
);

   typedef enum logic [1:0] {S_ACC, S_EMIT, S_TAIL} state_t;

   typedef struct packed {
      logic [4:0]       sym;
      logic [6:0]       extra;
      logic [2:0]       bits;
      logic [CNT_W-1:0] take;
   } enc_t;

   localparam logic [CNT_W-1:0] RUN_MAX = '1;

   // One greedy step: the symbol for the head of a run and how much of it it covers.
   function automatic enc_t enc_step(input logic [3:0] val, input logic [CNT_W-1:0] cnt,
                                     input logic first);
      enc_t r;
      int   c;
      int   t;
      r = '0;
      c = int'(cnt);
      t = 1;
      r.sym = {1'b0, val};
      if (val == 4'd0) begin
         if (c >= 11) begin
            t       = (c > 138) ? 138 : c;
            r.sym   = 5'd18;
            r.extra = 7'(t - 11);
            r.bits  = 3'd7;
         end else if (c >= 3) begin
            t       = c;
            r.sym   = 5'd17;
            r.extra = 7'(t - 3);
            r.bits  = 3'd3;
         end
      end else if (!first && c >= 3) begin
         t       = (c > 6) ? 6 : c;
         r.sym   = 5'd16;
         r.extra = 7'(t - 3);
         r.bits  = 3'd2;
      end
      r.take = CNT_W'(t);
      return r;
   endfunction

   state_t           state_q, state_d;
   logic [3:0]       cur_val_q, cur_val_d;
   logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
   logic [3:0]       emit_val_q, emit_val_d;
   logic [CNT_W-1:0] emit_cnt_q, emit_cnt_d;
   logic             final_q, final_d;
   logic             pend_q, pend_d;
   logic             ov_q, ov_d;
   logic [4:0]       osym_q, osym_d;
   logic [6:0]       oext_q, oext_d;
   logic [2:0]       obits_q, obits_d;
   logic             olast_q, olast_d;

   logic             load_sym;
   logic [3:0]       sel_val;
   logic [CNT_W-1:0] sel_cnt;
   logic [CNT_W-1:0] sel_rem;
   logic             sel_first, sel_final, sel_pend;
   logic             same;
   enc_t             step;

   always_comb begin
      state_d    = state_q;
      cur_val_d  = cur_val_q;
      run_cnt_d  = run_cnt_q;
      emit_val_d = emit_val_q;
      emit_cnt_d = emit_cnt_q;
      final_d    = final_q;
      pend_d     = pend_q;
      ov_d       = ov_q;
      osym_d     = osym_q;
      oext_d     = oext_q;
      obits_d    = obits_q;
      olast_d    = olast_q;
      load_sym   = 1'b0;
      sel_val    = emit_val_q;
      sel_cnt    = emit_cnt_q;
      sel_first  = 1'b0;
      sel_final  = final_q;
      sel_pend   = pend_q;
      same       = (run_cnt_q != '0) && (bus.in_len == cur_val_q) && (run_cnt_q != RUN_MAX);

      case (state_q)
         S_ACC: begin
            if (bus.in_valid) begin
               if (run_cnt_q == '0) begin
                  cur_val_d = bus.in_len;
                  if (bus.in_last) begin
                     // Lone final input: a one-long run that closes the sequence.
                     sel_val   = bus.in_len;
                     sel_cnt   = CNT_W'(1);
                     sel_first = 1'b1;
                     sel_final = 1'b1;
                     sel_pend  = 1'b0;
                     load_sym  = 1'b1;
                  end else begin
                     run_cnt_d = CNT_W'(1);
                  end
               end else if (same && !bus.in_last) begin
                  run_cnt_d = run_cnt_q + 1'b1;
               end else if (same) begin
                  sel_val   = cur_val_q;
                  sel_cnt   = run_cnt_q + 1'b1;
                  sel_first = 1'b1;
                  sel_final = 1'b1;
                  sel_pend  = 1'b0;
                  load_sym  = 1'b1;
               end else begin
                  sel_val   = cur_val_q;
                  sel_cnt   = run_cnt_q;
                  sel_first = 1'b1;
                  sel_final = 1'b0;
                  sel_pend  = bus.in_last;
                  cur_val_d = bus.in_len;
                  run_cnt_d = CNT_W'(1);
                  load_sym  = 1'b1;
               end
            end
         end
         S_EMIT: begin
            if (ov_q && bus.out_ready) begin
               if (emit_cnt_q != '0) begin
                  load_sym = 1'b1;
               end else if (pend_q) begin
                  state_d = S_TAIL;
                  pend_d  = 1'b0;
                  final_d = 1'b1;
                  osym_d  = {1'b0, cur_val_q};
                  oext_d  = '0;
                  obits_d = '0;
                  olast_d = 1'b1;
               end else begin
                  state_d = S_ACC;
                  ov_d    = 1'b0;
                  olast_d = 1'b0;
                  final_d = 1'b0;
                  if (final_q) run_cnt_d = '0;
               end
            end
         end
         S_TAIL: begin
            if (ov_q && bus.out_ready) begin
               state_d   = S_ACC;
               ov_d      = 1'b0;
               olast_d   = 1'b0;
               final_d   = 1'b0;
               run_cnt_d = '0;
            end
         end
         default: state_d = S_ACC;
      endcase

      step    = enc_step(sel_val, sel_cnt, sel_first);
      sel_rem = sel_cnt - step.take;
      if (load_sym) begin
         state_d    = S_EMIT;
         emit_val_d = sel_val;
         emit_cnt_d = sel_rem;
         final_d    = sel_final;
         pend_d     = sel_pend;
         ov_d       = 1'b1;
         osym_d     = step.sym;
         oext_d     = step.extra;
         obits_d    = step.bits;
         olast_d    = sel_final && (sel_rem == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_ACC;
         cur_val_q  <= '0;
         run_cnt_q  <= '0;
         emit_val_q <= '0;
         emit_cnt_q <= '0;
         final_q    <= 1'b0;
         pend_q     <= 1'b0;
         ov_q       <= 1'b0;
         osym_q     <= '0;
         oext_q     <= '0;
         obits_q    <= '0;
         olast_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cur_val_q  <= cur_val_d;
         run_cnt_q  <= run_cnt_d;
         emit_val_q <= emit_val_d;
         emit_cnt_q <= emit_cnt_d;
         final_q    <= final_d;
         pend_q     <= pend_d;
         ov_q       <= ov_d;
         osym_q     <= osym_d;
         oext_q     <= oext_d;
         obits_q    <= obits_d;
         olast_q    <= olast_d;
      end
   end

   assign bus.in_ready       = (state_q == S_ACC);
   assign bus.out_valid      = ov_q;
   assign bus.out_sym        = osym_q;
   assign bus.out_extra      = oext_q;
   assign bus.out_extra_bits = obits_q;
   assign bus.out_last       = olast_q;

endmodule

// File: tb/tb_cl_encode.sv
// Scoreboard bench for cl_encode: expected symbols are queued as stimulus is
// issued and a monitor pops them on every output handshake.
module tb_cl_encode;
   logic clk;
   logic reset;
   int   checks;
   int   errors;
   logic [15:0] sb[$];

   cl_encode_if b();

   cl_encode #(.CNT_W(9)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   // Packed as {last, extra_bits, extra, sym}.
   function automatic logic [15:0] E(input int sym, input int extra, input int bits, input int last);
      return {last[0], bits[2:0], extra[6:0], sym[4:0]};
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic send(input logic [3:0] l, input logic last);
      int n;
      n = 0;
      @(negedge clk);
      b.in_valid = 1'b1;
      b.in_len   = l;
      b.in_last  = last;
      while (!b.in_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) chk("in_ready_wait", 0, 1);
      @(posedge clk);
      #1 b.in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 600) begin
         @(negedge clk);
         n++;
      end
      if (n >= 600) chk("drain_wait", sb.size(), 0);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      reset      = 1'b1;
      b.in_valid = 1'b0;
      b.in_len   = '0;
      b.in_last  = 1'b0;
      b.out_ready = 1'b1;

      fork
         forever begin
            @(negedge clk);
            if (!reset && b.out_valid && b.out_ready) begin
               if (sb.size() == 0) begin
                  chk("unexpected_sym", {b.out_last, b.out_extra_bits, b.out_extra, b.out_sym}, 16'hFFFF);
               end else begin
                  chk("out_sym", {b.out_last, b.out_extra_bits, b.out_extra, b.out_sym}, sb.pop_front());
               end
            end
         end
      join_none

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", b.out_valid, 0);
      chk("rst_out_fields", {b.out_last, b.out_extra_bits, b.out_extra, b.out_sym}, 0);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", b.in_ready, 1);

      // 5 x 8, last on the 8th
      sb.push_back(E(5, 0, 0, 0));
      sb.push_back(E(16, 3, 2, 0));
      sb.push_back(E(5, 0, 0, 1));
      for (int i = 0; i < 8; i++) send(4'd5, i == 7);
      drain();

      // 0 x 20 then 3 (last)
      sb.push_back(E(18, 9, 7, 0));
      sb.push_back(E(3, 0, 0, 1));
      for (int i = 0; i < 20; i++) send(4'd0, 1'b0);
      send(4'd3, 1'b1);
      drain();

      // 0 x 139, last
      sb.push_back(E(18, 127, 7, 0));
      sb.push_back(E(0, 0, 0, 1));
      for (int i = 0; i < 139; i++) send(4'd0, i == 138);
      drain();

      // 0 x 7, last
      sb.push_back(E(17, 4, 3, 1));
      for (int i = 0; i < 7; i++) send(4'd0, i == 6);
      drain();

      // 0,0,7 (last); input stalled while emitting
      sb.push_back(E(0, 0, 0, 0));
      sb.push_back(E(0, 0, 0, 0));
      sb.push_back(E(7, 0, 0, 1));
      send(4'd0, 1'b0);
      send(4'd0, 1'b0);
      send(4'd7, 1'b1);
      @(negedge clk);
      chk("in_ready_emit", b.in_ready, 0);
      drain();

      // single input with last
      sb.push_back(E(9, 0, 0, 1));
      send(4'd9, 1'b1);
      drain();

      // backpressure on the repeat symbol of 5 x 8
      sb.push_back(E(5, 0, 0, 0));
      sb.push_back(E(16, 3, 2, 0));
      sb.push_back(E(5, 0, 0, 1));
      for (int i = 0; i < 8; i++) send(4'd5, i == 7);
      @(posedge clk);
      #1 b.out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_hold", {b.in_ready, b.out_valid, b.out_last, b.out_extra_bits, b.out_extra, b.out_sym},
             {2'b01, E(16, 3, 2, 0)});
      end
      @(posedge clk);
      #1 b.out_ready = 1'b1;
      drain();

      // reset during emission abandons the pending symbols
      for (int i = 0; i < 20; i++) send(4'd0, 1'b0);
      send(4'd3, 1'b1);
      b.out_ready = 1'b0;
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      b.out_ready = 1'b1;
      @(negedge clk);
      chk("mid_rst_out_valid", b.out_valid, 0);
      chk("mid_rst_in_ready", b.in_ready, 1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("mid_rst_quiet", b.out_valid, 0);
      end
      sb.push_back(E(4, 0, 0, 1));
      send(4'd4, 1'b1);
      drain();

      chk("sb_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
